// File: rtl/avalon_test_pkg.sv
// Shared types and constants for the Avalon-MM wait-state test slave.
package avalon_test_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  typedef enum logic {RD, WR} op_t;

  // Fibonacci feedback taps 16,14,13,11 (bit 15 is tap 16)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/avalon_wait_lfsr.sv
// 16-bit Fibonacci LFSR used to jitter wait states; steps once per accepted request.
module avalon_wait_lfsr
  import avalon_test_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Step,
  output logic [15:0] o_Val
);

  logic [15:0] r_Lfsr;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst)       r_Lfsr <= SEED;
    else if (i_Step) r_Lfsr <= {r_Lfsr[14:0], ^(r_Lfsr & LFSR_TAPS)};
  end

  assign o_Val = r_Lfsr;

endmodule

// File: rtl/avalon_wait_mem_slave.sv
// Avalon-MM test slave: DEPTH-word memory with programmable read/write wait states and a
// sticky protocol-error flag. Define AVALON_TEST_SLAVE_RAND_WAIT_EN to add LFSR wait jitter.
module avalon_wait_mem_slave
  import avalon_test_pkg::*;
#(
  parameter int          DATA_W                = 32,
  parameter int          ADDR_W                = 30,
  parameter int          NUM_PERIPH_SEL_BITS   = 5,
  parameter int          PERIPH_SEL            = 0,
  parameter int          DEPTH                 = 16,
  parameter int          WRITE_WAIT_REQ_CYCLES = 5,
  parameter int          READ_WAIT_REQ_CYCLES  = 4,
  parameter int          WAIT_CNT_W            = 8,
  parameter logic [15:0] RAND_WAIT_MASK        = 16'h000F,
  parameter logic [15:0] LFSR_SEED             = 16'hACE1
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic [ADDR_W-1:0]   i_AV_Addr,
  input  logic [DATA_W/8-1:0] i_AV_ByteEn,
  input  logic                i_AV_Read,
  output logic [DATA_W-1:0]   o_AV_ReadData,
  input  logic                i_AV_Write,
  input  logic [DATA_W-1:0]   i_AV_WriteData,
  output logic                o_AV_WaitRequest,
  output logic                o_ProtoErr
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = clog2(DEPTH);

  logic [DATA_W-1:0]     r_Mem [DEPTH];
  state_t                r_State;
  op_t                   r_Op;
  logic [ADDR_W-1:0]     r_Addr;
  logic [BE_W-1:0]       r_ByteEn;
  logic [DATA_W-1:0]     r_WData;
  logic [WAIT_CNT_W-1:0] r_Cnt;
  logic                  r_WaitReq;
  logic [DATA_W-1:0]     r_RData;
  logic                  r_ProtoErr;

  logic                  w_Sel, w_Req;
  op_t                   w_ReqOp;
  logic [WAIT_CNT_W-1:0] w_Base, w_N;
  logic [IDX_W-1:0]      w_InIdx, w_Idx;

  assign w_Sel   = (i_AV_Addr[ADDR_W-1 -: NUM_PERIPH_SEL_BITS] == NUM_PERIPH_SEL_BITS'(PERIPH_SEL));
  assign w_Req   = i_AV_Read | i_AV_Write;
  // Simultaneous read+write is served as a write
  assign w_ReqOp = i_AV_Write ? WR : RD;
  assign w_Base  = (w_ReqOp == WR) ? WAIT_CNT_W'(WRITE_WAIT_REQ_CYCLES)
                                   : WAIT_CNT_W'(READ_WAIT_REQ_CYCLES);
  assign w_InIdx = i_AV_Addr[IDX_W-1:0];
  assign w_Idx   = r_Addr[IDX_W-1:0];

`ifdef AVALON_TEST_SLAVE_RAND_WAIT_EN
  logic        w_Step;
  logic [15:0] w_Lfsr;

  assign w_Step = (r_State == IDLE) && w_Sel && w_Req;
  assign w_N    = w_Base + WAIT_CNT_W'(w_Lfsr & RAND_WAIT_MASK);

  avalon_wait_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .i_Clk  (i_Clk),
    .i_Rst  (i_Rst),
    .i_Step (w_Step),
    .o_Val  (w_Lfsr)
  );
`else
  assign w_N = w_Base;
`endif

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      for (int i = 0; i < DEPTH; i++) r_Mem[i] <= '0;
      r_State    <= IDLE;
      r_Op       <= RD;
      r_Addr     <= '0;
      r_ByteEn   <= '0;
      r_WData    <= '0;
      r_Cnt      <= '0;
      r_WaitReq  <= 1'b1;
      r_RData    <= '0;
      r_ProtoErr <= 1'b0;
    end else begin
      r_WaitReq <= 1'b1;
      r_RData   <= '0;
      if (w_Sel && i_AV_Read && i_AV_Write) r_ProtoErr <= 1'b1;
      case (r_State)
        IDLE: if (w_Sel && w_Req) begin
          r_Op     <= w_ReqOp;
          r_Addr   <= i_AV_Addr;
          r_ByteEn <= i_AV_ByteEn;
          r_WData  <= i_AV_WriteData;
          r_Cnt    <= w_N;
          if (w_N == '0) begin
            r_State   <= ACK;
            r_WaitReq <= 1'b0;
            if (w_ReqOp == RD) r_RData <= r_Mem[w_InIdx];
          end else begin
            r_State <= WAIT;
          end
        end
        WAIT: begin
          // Master must hold the same request until it is accepted
          if (!w_Req || (w_ReqOp != r_Op) || (i_AV_Addr != r_Addr)) r_ProtoErr <= 1'b1;
          r_Cnt <= r_Cnt - WAIT_CNT_W'(1);
          if (r_Cnt == WAIT_CNT_W'(1)) begin
            r_State   <= ACK;
            r_WaitReq <= 1'b0;
            if (r_Op == RD) r_RData <= r_Mem[w_Idx];
          end
        end
        ACK: begin
          r_State <= IDLE;
          if (r_Op == WR)
            for (int b = 0; b < BE_W; b++)
              if (r_ByteEn[b]) r_Mem[w_Idx][8*b +: 8] <= r_WData[8*b +: 8];
        end
        default: r_State <= IDLE;
      endcase
    end
  end

  assign o_AV_WaitRequest = r_WaitReq;
  assign o_AV_ReadData    = r_RData;
  assign o_ProtoErr       = r_ProtoErr;

endmodule

// File: tb/tb_avalon_wait_mem_slave.sv
// Self-checking bench for avalon_wait_mem_slave: directed table, random traffic vs. a memory model,
// and hand sequences for reset, protocol errors, address select and zero-wait operation.
module tb_avalon_wait_mem_slave;

  localparam int WW = 5, RW = 4;

  logic        i_Clk = 1'b0;
  logic        i_Rst = 1'b1;
  logic [29:0] addr = '0;
  logic [3:0]  be = '0;
  logic        rd = 1'b0, wr = 1'b0;
  logic [31:0] wd = '0, rdata;
  logic        wreq, perr;

  logic [29:0] z_addr = '0;
  logic        z_rd = 1'b0, z_wr = 1'b0;
  logic [31:0] z_wd = '0, z_rdata;
  logic        z_wreq, z_perr;

  int checks = 0, errors = 0;
  logic [31:0] model [16];

  always #5 i_Clk = ~i_Clk;

  avalon_wait_mem_slave dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_AV_Addr(addr), .i_AV_ByteEn(be), .i_AV_Read(rd),
    .o_AV_ReadData(rdata), .i_AV_Write(wr), .i_AV_WriteData(wd),
    .o_AV_WaitRequest(wreq), .o_ProtoErr(perr));

  avalon_wait_mem_slave #(.WRITE_WAIT_REQ_CYCLES(0), .READ_WAIT_REQ_CYCLES(0)) dut0 (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_AV_Addr(z_addr), .i_AV_ByteEn(4'hF), .i_AV_Read(z_rd),
    .o_AV_ReadData(z_rdata), .i_AV_Write(z_wr), .i_AV_WriteData(z_wd),
    .o_AV_WaitRequest(z_wreq), .o_ProtoErr(z_perr));

  typedef struct {
    bit          is_rd;
    logic [29:0] a;
    logic [3:0]  b;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_wait(input string name, input int act, input int base);
`ifdef AVALON_TEST_SLAVE_RAND_WAIT_EN
    checks++;
    if (act < base || act > base + 15) begin
      errors++;
      $display("FAIL %s: got %0d expected range %0d..%0d", name, act, base, base + 15);
    end
`else
    chk(name, act, base);
`endif
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // Drive one request and hold it until accepted; waits = WaitRequest-high cycles after request cycle
  task automatic xfer(input bit r, input bit w, input logic [29:0] a, input logic [3:0] b,
                      input logic [31:0] d, output logic [31:0] rdat, output int waits);
    int cnt;
    bit ok;
    addr = a; be = b; wd = d; rd = r; wr = w;
    cnt = 0; ok = 0; rdat = '0;
    for (int c = 0; c < 100; c++) begin
      @(negedge i_Clk);
      if (!wreq) begin rdat = rdata; ok = 1; break; end
      cnt++;
    end
    if (!ok) chk("xfer_timeout", 32'd0, 32'd1);
    waits = cnt - 1;
    @(posedge i_Clk); #1;
    rd = 0; wr = 0;
  endtask

  task automatic reset_pulse();
    @(posedge i_Clk); #1 i_Rst = 1;
    @(posedge i_Clk); #1 i_Rst = 0;
    for (int i = 0; i < 16; i++) model[i] = '0;
  endtask

  initial begin
    vec_t tbl [7];
    logic [31:0] rv;
    int waits, hi;
    bit done;

    tbl[0] = '{0, 30'd0,  4'hF, 32'h5A5A5A5A, 32'h0};
    tbl[1] = '{1, 30'd0,  4'h0, 32'h0,        32'h5A5A5A5A};
    tbl[2] = '{0, 30'd0,  4'h5, 32'h11223344, 32'h0};
    tbl[3] = '{1, 30'd0,  4'h0, 32'h0,        32'h5A225A44};
    tbl[4] = '{0, 30'd17, 4'hF, 32'hCAFEF00D, 32'h0};
    tbl[5] = '{1, 30'd1,  4'h0, 32'h0,        32'hCAFEF00D};
    tbl[6] = '{1, 30'd15, 4'h0, 32'h0,        32'h0};
    for (int i = 0; i < 16; i++) model[i] = '0;

    // Reset state
    repeat (3) @(posedge i_Clk);
    @(negedge i_Clk);
    chk("rst_wreq", wreq, 1);
    chk("rst_rdata", rdata, 0);
    chk("rst_perr", perr, 0);
    @(posedge i_Clk); #1 i_Rst = 0;

    // Directed table
    foreach (tbl[i]) begin
      xfer(tbl[i].is_rd, !tbl[i].is_rd, tbl[i].a, tbl[i].b, tbl[i].d, rv, waits);
      chk_wait($sformatf("tbl%0d_wait", i), waits, tbl[i].is_rd ? RW : WW);
      if (tbl[i].is_rd) chk($sformatf("tbl%0d_rdata", i), rv, tbl[i].exp);
      else model[tbl[i].a % 16] = merge(model[tbl[i].a % 16], tbl[i].d, tbl[i].b);
    end
    chk("tbl_perr", perr, 0);

    // Unselected peripheral: never accepted, memory untouched
    addr = {5'd1, 25'd0}; wd = 32'hDEADBEEF; be = 4'hF; wr = 1;
    hi = 0;
    repeat (20) begin @(negedge i_Clk); if (wreq) hi++; end
    @(posedge i_Clk); #1 wr = 0;
    chk("unsel_wreq_cycles", hi, 20);
    xfer(1, 0, 30'd0, 4'h0, 32'h0, rv, waits);
    chk("unsel_mem", rv, model[0]);

    // Random traffic against the memory model, with aliasing in-window upper bits
    for (int i = 0; i < 40; i++) begin
      bit r;
      logic [29:0] a;
      logic [3:0] b;
      logic [31:0] d;
      r = $urandom_range(0, 1);
      a = {5'd0, 25'($urandom)};
      b = 4'($urandom);
      d = $urandom;
      xfer(r, !r, a, b, d, rv, waits);
      chk_wait("rnd_wait", waits, r ? RW : WW);
      if (r) chk("rnd_rdata", rv, model[a % 16]);
      else model[a % 16] = merge(model[a % 16], d, b);
    end
    chk("rnd_perr", perr, 0);

    // Read and write together: write served, sticky error
    xfer(1, 1, 30'd3, 4'hF, 32'h0BADF00D, rv, waits);
    model[3] = 32'h0BADF00D;
    chk_wait("both_wait", waits, WW);
    chk("both_perr", perr, 1);
    xfer(1, 0, 30'd3, 4'h0, 32'h0, rv, waits);
    chk("both_rdata", rv, 32'h0BADF00D);
    chk("both_perr_sticky", perr, 1);
    reset_pulse();
    @(negedge i_Clk);
    chk("perr_cleared", perr, 0);

    // Request dropped during WAIT: error flagged, transfer still completes
    @(posedge i_Clk); #1 addr = 30'd4; rd = 1;
    @(posedge i_Clk); @(posedge i_Clk); #1 rd = 0;
    done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge i_Clk);
      if (!wreq) begin done = 1; break; end
    end
    chk("drop_completes", done, 1);
    chk("drop_perr", perr, 1);
    reset_pulse();

    // Reset during write WAIT aborts the write
    @(posedge i_Clk); #1 addr = 30'd2; wd = 32'h12345678; be = 4'hF; wr = 1;
    repeat (3) @(posedge i_Clk);
    #1 i_Rst = 1;
    #1;
    chk("rstmid_wreq", wreq, 1);
    chk("rstmid_rdata", rdata, 0);
    wr = 0;
    @(posedge i_Clk); #1 i_Rst = 0;
    xfer(1, 0, 30'd2, 4'h0, 32'h0, rv, waits);
    chk("rstmid_mem", rv, 32'h0);

`ifndef AVALON_TEST_SLAVE_RAND_WAIT_EN
    // Zero-wait instance: accepted in the cycle after the request, aliasing addr 17 -> 1
    @(posedge i_Clk); #1 z_addr = 30'd17; z_wd = 32'hA5C3E1F0; z_wr = 1;
    @(negedge i_Clk); chk("z_wr_reqcyc", z_wreq, 1);
    @(negedge i_Clk); chk("z_wr_accept", z_wreq, 0);
    @(posedge i_Clk); #1 z_wr = 0; z_addr = 30'd1; z_rd = 1;
    @(negedge i_Clk); chk("z_rd_reqcyc", z_wreq, 1);
    @(negedge i_Clk); chk("z_rd_accept", z_wreq, 0); chk("z_rdata", z_rdata, 32'hA5C3E1F0);
    @(posedge i_Clk); #1 z_rd = 0;
    chk("z_perr", z_perr, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
